// File: rtl/mlp_tile_sequencer.sv
// MLP layer sequencer: DRAM->GLB load, K-tiled compute on the ROWS x COLS PE array, ofmap drain through the PPU.
// Define MLP_SEQ_PERF_CNT_EN to add the cycle_cnt / stall_cnt performance counters.
module mlp_tile_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int MAX_DIM = 256,
  parameter int ADDR_W  = 12,
  parameter int DIM_W   = $clog2(MAX_DIM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_dim,
  input  logic [DIM_W-1:0]  out_dim,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              dram_valid,
  output logic              dram_ready,
  output logic              ifmap_wen,
  output logic              weight_wen,
  output logic              bias_wen,
  output logic              ifmap_ren,
  output logic              weight_ren,
  output logic              bias_ren,
  output logic [ADDR_W-1:0] glb_addr,
  output logic              arr_en,
  input  logic              arr_valid,
  output logic              psum_sel,
  output logic              psum_load,
  output logic              ofmap_wen,
  output logic              ofmap_ren,
  output logic [ADDR_W-1:0] ofmap_addr,
  output logic              ppu_en,
  input  logic              out_ready
`ifdef MLP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int ACT_PER_WORD = DATA_W / 8;
  localparam int PROD_W       = 2 * DIM_W;
  localparam int CNT_W        = (PROD_W > ADDR_W + 3) ? PROD_W : ADDR_W + 3;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IF, S_LOAD_W, S_LOAD_B,
    S_RD, S_ISSUE, S_WAIT, S_DR_RD, S_DR_OUT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   in_dim_q, in_dim_d, out_dim_q, out_dim_d;
  logic [DIM_W-1:0]   kt_q, kt_d, ot_q, ot_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, wbase_q, wbase_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   req_prod, ifw, ww, bw, load_cnt, idx_nxt;
  logic [DIM_W-1:0]   kt_total, ot_total;
  logic               start_ok;

  // The weight image (in*out/ACT_PER_WORD words) must fit the GLB address space.
  assign req_prod = CNT_W'(in_dim) * CNT_W'(out_dim);
  assign start_ok = (in_dim != '0) && (out_dim != '0)
                 && (in_dim <= DIM_W'(MAX_DIM)) && (out_dim <= DIM_W'(MAX_DIM))
                 && ((in_dim % DIM_W'(COLS)) == '0) && ((out_dim % DIM_W'(ROWS)) == '0)
                 && (req_prod <= (CNT_W'(ACT_PER_WORD) << ADDR_W));

  assign ifw      = CNT_W'(in_dim_q) / CNT_W'(ACT_PER_WORD);
  assign ww       = (CNT_W'(in_dim_q) * CNT_W'(out_dim_q)) / CNT_W'(ACT_PER_WORD);
  assign bw       = CNT_W'(out_dim_q);
  assign kt_total = in_dim_q / DIM_W'(COLS);
  assign ot_total = out_dim_q / DIM_W'(ROWS);
  assign idx_nxt  = CNT_W'(idx_q) + CNT_W'(1);
  assign load_cnt = (state_q == S_LOAD_IF) ? ifw : (state_q == S_LOAD_W) ? ww : bw;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err  = err_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      in_dim_q  <= '0;
      out_dim_q <= '0;
      kt_q      <= '0;
      ot_q      <= '0;
      idx_q     <= '0;
      wbase_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_dim_q  <= in_dim_d;
      out_dim_q <= out_dim_d;
      kt_q      <= kt_d;
      ot_q      <= ot_d;
      idx_q     <= idx_d;
      wbase_q   <= wbase_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    in_dim_d   = in_dim_q;
    out_dim_d  = out_dim_q;
    kt_d       = kt_q;
    ot_d       = ot_q;
    idx_d      = idx_q;
    wbase_d    = wbase_q;
    err_d      = 1'b0;
    done       = 1'b0;
    dram_ready = 1'b0;
    ifmap_wen  = 1'b0;
    weight_wen = 1'b0;
    bias_wen   = 1'b0;
    ifmap_ren  = 1'b0;
    weight_ren = 1'b0;
    bias_ren   = 1'b0;
    glb_addr   = '0;
    arr_en     = 1'b0;
    psum_sel   = 1'b0;
    psum_load  = 1'b0;
    ofmap_wen  = 1'b0;
    ofmap_ren  = 1'b0;
    ofmap_addr = '0;
    ppu_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d   = S_LOAD_IF;
            in_dim_d  = in_dim;
            out_dim_d = out_dim;
            kt_d      = '0;
            ot_d      = '0;
            idx_d     = '0;
            wbase_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD_IF, S_LOAD_W, S_LOAD_B: begin
        dram_ready = 1'b1;
        glb_addr   = idx_q;
        if (dram_valid) begin
          ifmap_wen  = (state_q == S_LOAD_IF);
          weight_wen = (state_q == S_LOAD_W);
          bias_wen   = (state_q == S_LOAD_B);
          if (idx_nxt == load_cnt) begin
            idx_d   = '0;
            state_d = (state_q == S_LOAD_IF) ? S_LOAD_W :
                      (state_q == S_LOAD_W)  ? S_LOAD_B : S_RD;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      // glb_addr carries the weight address; the top derives the ifmap (kt) and bias (ot) reads itself.
      S_RD: begin
        ifmap_ren  = 1'b1;
        weight_ren = 1'b1;
        bias_ren   = 1'b1;
        glb_addr   = wbase_q + ADDR_W'(kt_q);
        state_d    = S_ISSUE;
      end

      S_ISSUE: begin
        arr_en   = 1'b1;
        psum_sel = (kt_q != '0);
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (arr_valid) begin
          if (kt_q != kt_total - DIM_W'(1)) begin
            psum_load = 1'b1;
            kt_d      = kt_q + DIM_W'(1);
            state_d   = S_RD;
          end else begin
            ofmap_wen  = 1'b1;
            ofmap_addr = ADDR_W'(ot_q);
            kt_d       = '0;
            ot_d       = ot_q + DIM_W'(1);
            wbase_d    = wbase_q + ADDR_W'(kt_total);
            if (ot_q == ot_total - DIM_W'(1)) begin
              idx_d   = '0;
              state_d = S_DR_RD;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end

      S_DR_RD: begin
        ofmap_ren  = 1'b1;
        ofmap_addr = idx_q;
        state_d    = S_DR_OUT;
      end

      S_DR_OUT: begin
        ppu_en     = 1'b1;
        ofmap_addr = idx_q;
        if (out_ready) begin
          if (idx_nxt == bw) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_DR_RD;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef MLP_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start && start_ok) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (busy) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if ((state_q == S_DR_OUT) && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mlp_tile_sequencer.sv
// Scoreboard bench for mlp_tile_sequencer: a layer-level model queues expected GLB/array/drain events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_mlp_tile_sequencer;
  localparam int DIM_W  = 9;
  localparam int ADDR_W = 12;
  localparam int K_IF = 0, K_W = 1, K_B = 2, K_RD = 3, K_ARR = 4, K_PSUM = 5, K_OWR = 6;

  typedef struct { int kind; int val; } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  in_dim = '0, out_dim = '0;
  logic              busy, done, err;
  logic              dram_valid = 1'b0, dram_ready;
  logic              ifmap_wen, weight_wen, bias_wen, ifmap_ren, weight_ren, bias_ren;
  logic [ADDR_W-1:0] glb_addr, ofmap_addr;
  logic              arr_en, arr_valid = 1'b0, psum_sel, psum_load;
  logic              ofmap_wen, ofmap_ren, ppu_en, out_ready = 1'b1;
`ifdef MLP_SEQ_PERF_CNT_EN
  logic [31:0]       cycle_cnt, stall_cnt;
`endif

  mlp_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_dim(in_dim), .out_dim(out_dim),
    .busy(busy), .done(done), .err(err), .dram_valid(dram_valid), .dram_ready(dram_ready),
    .ifmap_wen(ifmap_wen), .weight_wen(weight_wen), .bias_wen(bias_wen),
    .ifmap_ren(ifmap_ren), .weight_ren(weight_ren), .bias_ren(bias_ren),
    .glb_addr(glb_addr), .arr_en(arr_en), .arr_valid(arr_valid), .psum_sel(psum_sel),
    .psum_load(psum_load), .ofmap_wen(ofmap_wen), .ofmap_ren(ofmap_ren),
    .ofmap_addr(ofmap_addr), .ppu_en(ppu_en), .out_ready(out_ready)
`ifdef MLP_SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  ev_t load_q[$];
  ev_t comp_q[$];
  int  drain_q[$];
  int  err_pend = 0, done_pend = 0;
  int  checks = 0, errors = 0;
  int  dram_mode = 0, lat_fixed = 2, busy_cycles = 0;
  bit  rdy_rand = 1'b0, arm_stall = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int i, input int o);
    return i > 0 && o > 0 && i <= 256 && o <= 256 && i % 8 == 0 && o % 8 == 0 && i * o <= 4 * 4096;
  endfunction

  // Layer-level model: word counts, tile loop order and drain order straight from the layer dimensions.
  task automatic model_push(input int i, input int o);
    int kt_n = i / 8;
    int ot_n = o / 8;
    for (int n = 0; n < i / 4; n++) load_q.push_back('{K_IF, n});
    for (int n = 0; n < i * o / 4; n++) load_q.push_back('{K_W, n});
    for (int n = 0; n < o; n++) load_q.push_back('{K_B, n});
    for (int ot = 0; ot < ot_n; ot++)
      for (int kt = 0; kt < kt_n; kt++) begin
        comp_q.push_back('{K_RD, ot * kt_n + kt});
        comp_q.push_back('{K_ARR, int'(kt != 0)});
        if (kt < kt_n - 1) comp_q.push_back('{K_PSUM, 0});
        else               comp_q.push_back('{K_OWR, ot});
      end
    for (int n = 0; n < o; n++) drain_q.push_back(n);
    done_pend++;
  endtask

  task automatic comp_event(input string name, input int k, input int v);
    ev_t e;
    check({name, "_pending"}, int'(comp_q.size() != 0), 1);
    if (comp_q.size() != 0) begin
      e = comp_q.pop_front();
      check({name, "_order"}, k, e.kind);
      check({name, "_value"}, v, e.val);
    end
  endtask

  ev_t mon_e;
  int  mon_k, mon_wen;

  always @(negedge clk) begin
    if (!rst) begin
      mon_wen = int'(ifmap_wen) + int'(weight_wen) + int'(bias_wen);
      if (mon_wen != 0 || (dram_valid && dram_ready)) begin
        check("load_handshake", mon_wen, int'(dram_valid && dram_ready));
        if (mon_wen != 0) begin
          mon_k = ifmap_wen ? K_IF : weight_wen ? K_W : K_B;
          check("load_pending", int'(load_q.size() != 0), 1);
          if (load_q.size() != 0) begin
            mon_e = load_q.pop_front();
            check("load_kind", mon_k, mon_e.kind);
            check("load_addr", int'(glb_addr), mon_e.val);
          end
        end
      end
      if (weight_ren) begin
        check("rd_together", int'(ifmap_ren && bias_ren), 1);
        comp_event("rd", K_RD, int'(glb_addr));
      end
      if (arr_en)    comp_event("arr_en", K_ARR, int'(psum_sel));
      if (psum_load) comp_event("psum_load", K_PSUM, 0);
      if (ofmap_wen) comp_event("ofmap_wen", K_OWR, int'(ofmap_addr));
      if (ofmap_ren || ppu_en) begin
        check("drain_pending", int'(drain_q.size() != 0), 1);
        if (drain_q.size() != 0) begin
          if (ppu_en && out_ready) check("drain_addr", int'(ofmap_addr), drain_q.pop_front());
          else if (ppu_en)         check("stall_addr", int'(ofmap_addr), drain_q[0]);
          else                     check("drain_rd_addr", int'(ofmap_addr), drain_q[0]);
        end
      end
      if (done) begin
        check("done_pending", int'(done_pend > 0), 1);
        if (done_pend > 0) done_pend--;
        check("done_after_all", load_q.size() + comp_q.size() + drain_q.size(), 0);
        check("done_busy_low", int'(busy), 0);
      end
      if (err) begin
        check("err_pending", int'(err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
      end
    end
  end

  always @(negedge clk) begin
    if (start && !busy) busy_cycles = 0;
    else if (busy)      busy_cycles++;
  end

  always @(posedge clk) begin
    #1;
    case (dram_mode)
      0:       dram_valid = 1'b1;
      1:       dram_valid = ~dram_valid;
      default: dram_valid = 1'($urandom_range(0, 1));
    endcase
  end

  always begin
    @(negedge clk);
    if (arr_en && !rst) begin
      repeat ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3))) @(posedge clk);
      #1 arr_valid = 1'b1;
      @(posedge clk);
      #1 arr_valid = 1'b0;
    end
  end

  // Armed stall: the five cycles right after an ofmap read hold out_ready low.
  always begin
    @(negedge clk);
    if (arm_stall && ofmap_ren) begin
      arm_stall = 1'b0;
      repeat (5) begin
        @(posedge clk);
        #1 out_ready = 1'b0;
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end else begin
      @(posedge clk);
      #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_start(input int i, input int o);
    bit ok = legal(i, o);
    if (ok) model_push(i, o);
    else    err_pend++;
    @(posedge clk);
    #1;
    start   = 1'b1;
    in_dim  = DIM_W'(i);
    out_dim = DIM_W'(o);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check($sformatf("busy_after_start_%0dx%0d", i, o), int'(busy), int'(ok));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_pend > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", int'(done_pend == 0), 1);
    check("queues_empty", load_q.size() + comp_q.size() + drain_q.size(), 0);
  endtask

  task automatic wait_arr_en(input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      seen = arr_en;
      n++;
    end
    check("arr_en_in_time", int'(seen), 1);
  endtask

  function automatic int any_output();
    return int'(|{busy, done, err, dram_ready, ifmap_wen, weight_wen, bias_wen, ifmap_ren,
                  weight_ren, bias_ren, glb_addr, arr_en, psum_sel, psum_load, ofmap_wen,
                  ofmap_ren, ofmap_addr, ppu_en});
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", any_output(), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Minimal layer, fixed 2-cycle array latency
    do_start(8, 8);
    wait_done(2000);

    // K accumulation, plus a start while busy that must be ignored
    lat_fixed = 0;
    do_start(32, 16);
    wait_arr_en(2000);
    @(posedge clk);
    #1;
    start = 1'b1; in_dim = 9'd8; out_dim = 9'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored", int'(busy), 1);
    wait_done(5000);

    // Rejected starts
    do_start(12, 8);
    do_start(8, 0);
    do_start(8, 12);
    do_start(264, 8);
    do_start(256, 256);
    repeat (3) @(negedge clk);
    check("err_all_seen", err_pend, 0);
    check("idle_after_rejects", int'(busy), 0);

    // Backpressure: toggling dram_valid and a 5-cycle out_ready stall
    dram_mode = 1;
    arm_stall = 1'b1;
    do_start(16, 24);
    wait_done(5000);
`ifdef MLP_SEQ_PERF_CNT_EN
    check("stall_cnt", int'(stall_cnt), 5);
    check("cycle_cnt", int'(cycle_cnt), busy_cycles);
`endif

    // Reset while waiting on the array
    dram_mode = 0;
    lat_fixed = 3;
    do_start(16, 8);
    wait_arr_en(2000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_q.delete();
    comp_q.delete();
    drain_q.delete();
    done_pend = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("outputs_after_abort", any_output(), 0);
    repeat (10) @(negedge clk);
    check("idle_after_abort", int'(busy), 0);
    do_start(16, 8);
    wait_done(5000);

    // Random layers under random backpressure and array latency
    lat_fixed = 0;
    dram_mode = 2;
    rdy_rand  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      do_start(8 * int'($urandom_range(1, 8)), 8 * int'($urandom_range(1, 8)));
      wait_done(20000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
